// File: rtl/mult_accum_if.sv
// rtl/mult_accum_if.sv - product-in / sum-out handshake bundle for mult_accum
interface mult_accum_if #(
  parameter int PROD_W = 10,
  parameter int ACC_W  = 14,
  parameter int CNT_W  = 3
);
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] prod_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     busy;
  logic [CNT_W-1:0]         count;

  modport master (
    output start, in_valid, prod_in, out_ready,
    input  in_ready, out_valid, acc_out, busy, count
  );

  modport slave (
    input  start, in_valid, prod_in, out_ready,
    output in_ready, out_valid, acc_out, busy, count
  );
endinterface

// File: rtl/mult_accum.sv
// rtl/mult_accum.sv - sequential multiply-accumulate back end
// Sums N_TERMS signed products per run and holds the result until taken.
module mult_accum #(
  parameter int PROD_W  = 10,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 14,
  parameter int CNT_W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0]        count_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic                    busy_q;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_d;
  logic                    beat;
  logic                    take;

  // in_ready_q is only ever high in ACCUM, so it doubles as the accept gate.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
    sum_d    = acc_q + prod_ext;
    beat     = bus.in_valid & in_ready_q;
    take     = out_valid_q & bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_out_q   <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ACCUM: begin
          if (beat) begin
            acc_q <= sum_d;
            if (count_q == LAST_CNT) begin
              state_q     <= DONE;
              acc_out_q   <= sum_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              count_q     <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end

        DONE: begin
          if (take) begin
            out_valid_q <= 1'b0;
            // A start coinciding with the hand-off chains straight into the next run.
            if (bus.start) begin
              state_q    <= ACCUM;
              acc_q      <= '0;
              count_q    <= '0;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_mult_accum.sv
// tb/tb_mult_accum.sv - directed table-driven bench for mult_accum
module tb_mult_accum;

  typedef struct packed {
    logic [0:7][9:0]  prods;
    logic [0:7][1:0]  gaps;
    logic signed [13:0] exp_sum;
  } run_vec_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  mult_accum_if #(.PROD_W(10), .ACC_W(14), .CNT_W(3)) bus ();

  mult_accum #(.PROD_W(10), .N_TERMS(8), .ACC_W(14), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input integer act, input integer exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic do_start();
    bus.in_valid = 1'b1;
    bus.prod_in  = 10'sd99;
    @(negedge clk);
    chk("idle in_valid ignored count", integer'(bus.count), 0);
    chk("idle in_ready", integer'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start in_ready", integer'(bus.in_ready), 1);
    chk("start busy", integer'(bus.busy), 1);
    chk("start count", integer'(bus.count), 0);
  endtask

  task automatic feed(input run_vec_t v, input string nm);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < int'(v.gaps[k]); j++) begin
        bus.in_valid = 1'b0;
        bus.prod_in  = 10'sd85;
        bus.start    = 1'b1;
        @(negedge clk);
        chk($sformatf("%s gap count k=%0d", nm, k), integer'(bus.count), k);
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.prod_in  = v.prods[k];
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (k < 7) chk($sformatf("%s count after beat %0d", nm, k + 1), integer'(bus.count), k + 1);
    end
    chk({nm, " out_valid"}, integer'(bus.out_valid), 1);
    chk({nm, " acc_out"}, integer'(bus.acc_out), integer'(v.exp_sum));
    chk({nm, " count wrap"}, integer'(bus.count), 0);
    chk({nm, " in_ready low"}, integer'(bus.in_ready), 0);
  endtask

  task automatic release_out(input logic signed [13:0] exp_sum, input string nm);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, " out_valid cleared"}, integer'(bus.out_valid), 0);
    chk({nm, " busy cleared"}, integer'(bus.busy), 0);
    chk({nm, " acc_out retained"}, integer'(bus.acc_out), integer'(exp_sum));
  endtask

  run_vec_t vecs [0:5];

  initial begin
    vecs[0] = '{prods: {8{10'sd1}}, gaps: {8{2'd0}}, exp_sum: 14'sd8};
    vecs[1] = '{prods: {8{10'sd256}}, gaps: {8{2'd0}}, exp_sum: 14'h0800};
    vecs[2] = '{prods: {8{-10'sd248}}, gaps: {8{2'd0}}, exp_sum: 14'h3840};
    vecs[3] = '{prods: {10'sd7, -10'sd3, 10'sd100, -10'sd248, 10'sd0, 10'sd1, -10'sd1, 10'sd5},
                gaps:  {2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2},
                exp_sum: -14'sd139};
    vecs[4] = '{prods: {8{10'sd3}}, gaps: {2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0}, exp_sum: 14'sd24};
    vecs[5] = '{prods: {8{10'sd2}}, gaps: {8{2'd0}}, exp_sum: 14'sd16};

    tests_run    = 0;
    tests_failed = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.prod_in   = '0;
    bus.out_ready = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start     = ~bus.start;
      bus.in_valid  = ~bus.in_valid;
      bus.out_ready = ~bus.out_ready;
      bus.prod_in   = 10'(i * 37);
    end
    @(negedge clk);
    chk("reset acc_out", integer'(bus.acc_out), 0);
    chk("reset out_valid", integer'(bus.out_valid), 0);
    chk("reset in_ready", integer'(bus.in_ready), 0);
    chk("reset busy", integer'(bus.busy), 0);
    chk("reset count", integer'(bus.count), 0);
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", integer'(bus.in_ready), 0);
    chk("post-reset busy", integer'(bus.busy), 0);

    for (int r = 0; r < 4; r++) begin
      do_start();
      feed(vecs[r], $sformatf("run%0d", r));
      release_out(vecs[r].exp_sum, $sformatf("run%0d", r));
    end

    // DONE hold while start/in_valid toggle, then back-to-back restart
    do_start();
    feed(vecs[4], "hold");
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = i[0];
      bus.in_valid  = ~i[0];
      bus.prod_in   = 10'sd100;
      @(negedge clk);
      chk($sformatf("hold out_valid c%0d", i), integer'(bus.out_valid), 1);
      chk($sformatf("hold acc_out c%0d", i), integer'(bus.acc_out), 24);
      chk($sformatf("hold in_ready c%0d", i), integer'(bus.in_ready), 0);
      chk($sformatf("hold busy c%0d", i), integer'(bus.busy), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("b2b out_valid", integer'(bus.out_valid), 0);
    chk("b2b in_ready", integer'(bus.in_ready), 1);
    chk("b2b busy", integer'(bus.busy), 1);
    chk("b2b count", integer'(bus.count), 0);
    feed(vecs[0], "b2b");
    release_out(vecs[0].exp_sum, "b2b");

    // Abort after 3 beats via async reset
    do_start();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.prod_in  = 10'sd50;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("abort pre count", integer'(bus.count), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort acc_out", integer'(bus.acc_out), 0);
    chk("abort count", integer'(bus.count), 0);
    chk("abort in_ready", integer'(bus.in_ready), 0);
    chk("abort busy", integer'(bus.busy), 0);
    chk("abort out_valid", integer'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    feed(vecs[5], "after-abort");
    release_out(vecs[5].exp_sum, "after-abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
